// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per clock.
// Supports unsigned and two's-complement operands via magnitude conversion
// and a final sign correction. Result packs {remainder, quotient}.
// Optional feature macro: DIV_ITER_EARLY_OUT_EN -- when defined, a nonzero
// divisor larger in magnitude than the dividend finishes at acceptance.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;
  localparam int         CW       = $clog2(WIDTH + 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     r_rem;     // partial remainder
  logic [WIDTH-1:0]   r_quo;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvs;     // divisor magnitude
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  // Operand signs and magnitudes seen at acceptance
  logic               w_sign1;
  logic               w_sign2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;

  // One restoring step: shift in the next dividend bit, try to subtract
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_sign1   = signed_div_i & opdata1_i[WIDTH-1];
  assign w_sign2   = signed_div_i & opdata2_i[WIDTH-1];
  assign w_mag1    = w_sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_mag2    = w_sign2 ? (~opdata2_i + 1'b1) : opdata2_i;

  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {2'b00, r_dvs});
  assign w_diff    = w_shift[WIDTH:0] - {1'b0, r_dvs};

  // Most-negative / -1 needs no special case: the magnitude quotient already
  // equals the most-negative pattern and no negation is applied.
  assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

  assign result_o  = r_result;
  assign ready_o   = r_ready;
  assign busy_o    = (r_state == S_BYZERO) || (r_state == S_ON);

  // Control FSM and datapath registers; reset is asynchronous, active-low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          // annul_i has priority over a pending start request
          if (start_i && !annul_i) begin
            r_quo   <= w_mag1;
            r_dvs   <= w_mag2;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_sign1 ^ w_sign2;
            r_neg_r <= w_sign1;
            if (opdata2_i == '0) begin
              r_state <= S_BYZERO;
`ifdef DIV_ITER_EARLY_OUT_EN
            end else if (w_mag1 < w_mag2) begin
              // Quotient is zero and the dividend is already the remainder
              r_state  <= S_END;
              r_ready  <= 1'b1;
              r_result <= {opdata1_i, {WIDTH{1'b0}}};
`endif
            end else begin
              r_state <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          r_result <= '0;
          if (annul_i) begin
            r_state <= S_FREE;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_END;
            r_ready <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= '0;
          end else if (r_cnt == CW'(WIDTH)) begin
            r_state  <= S_END;
            r_ready  <= 1'b1;
            r_result <= {w_rem_fix, w_quo_fix};
          end else begin
            r_rem <= w_ge ? w_diff : w_shift[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_END: begin
          // Result is held until the requester drops start_i
          if (!start_i) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= '0;
          end
        end
        default: begin
          r_state  <= S_FREE;
          r_ready  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed + random checks of div_iter (WIDTH=32) using a
// scoreboard queue of expected {remainder, quotient} results.
// Honours DIV_ITER_EARLY_OUT_EN for the expected latency.
module tb_div_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb_q[$];

  div_iter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: native arithmetic, truncating division, remainder follows dividend
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int exp_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    if (b == '0) return 2;
`ifdef DIV_ITER_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return W + 2;
`endif
    return W + 2;
  endfunction

  // One full transaction: accept, wait for ready, hold, release
  task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat;
    int k;
    logic [2*W-1:0] exp;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    sb_q.push_back(model(s, a, b));
    lat = exp_lat(s, a, b);
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        check({tag, " busy_e1"}, 64'(busy_o), 64'(lat > 1));
        // Operand changes after acceptance must not matter
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5;
        signed_div_i = ~s;
      end
      if (ready_o) break;
    end
    check({tag, " latency"}, 64'(k), 64'(lat));
    exp = sb_q.pop_front();
    check({tag, " result"}, result_o, exp);
    // Hold in END with annul asserted (must be ignored)
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " hold_ready"}, 64'(ready_o), 64'd1);
    check({tag, " hold_result"}, result_o, exp);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " rel_ready"}, 64'(ready_o), 64'd0);
    check({tag, " rel_result"}, result_o, 64'd0);
    $display("txn %s s=%0d a=%h b=%h -> %h lat=%0d", tag, s, a, b, exp, lat);
  endtask

  initial begin
    logic any_ready;
    // Asynchronous reset assertion, between clock edges
    #2 rst = 1'b0;
    #1;
    check("rst ready", 64'(ready_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst result", result_o, 64'd0);
    start_i = 1'b1;
    opdata1_i = 32'd8; opdata2_i = 32'd2;
    @(posedge clk); #1;
    check("rst hold busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;

    // annul_i beats start_i in FREE
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("annul_free busy", 64'(busy_o), 64'd0);
    check("annul_free ready", 64'(ready_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, "u100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "s-7_2");
    do_div(1'b0, 32'd5, 32'd0, "u5_0");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_min_m1");
    do_div(1'b0, 32'd3, 32'd10, "u3_10");
    do_div(1'b1, 32'hFFFF_FFFD, 32'd10, "s-3_10");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_-2");
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, "s-100_-7");
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "umax_1");
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "u_big_max");

    // Abort: annul_i raised after edge 10, FREE after edge 11
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    start_i = 1'b1; annul_i = 1'b0;
    any_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      any_ready |= ready_o;
    end
    check("abort busy_on", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(posedge clk); #1;
    any_ready |= ready_o;
    check("abort busy", 64'(busy_o), 64'd0);
    check("abort ready_seen", 64'(any_ready), 64'd0);
    check("abort result", result_o, 64'd0);
    @(posedge clk); #1;
    check("abort stay_free", 64'(busy_o), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, "restart9_3");

    // Asynchronous reset in the middle of ON
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    check("midrst busy_before", 64'(busy_o), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b0, 32'd1000, 32'd3, "post_rst");

    // Random operands, both signednesses, mixed divisor sizes
    for (int i = 0; i < 8; i++) begin
      logic s;
      logic [W-1:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) b = '0;
      do_div(s, a, b, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 8..64).
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have port signed_div_i, input, 1: 1 = two's-complement divide, 0 = unsigned divide.
REQ-005 SHALL have port opdata1_i, input, WIDTH: dividend.
REQ-006 SHALL have port opdata2_i, input, WIDTH: divisor.
REQ-007 SHALL have port start_i, input, 1: request level; held high until the result is consumed.
REQ-008 SHALL have port annul_i, input, 1: abort an in-flight divide.
REQ-009 SHALL have port result_o, output, 2*WIDTH: [2*WIDTH-1:WIDTH] remainder, [WIDTH-1:0] quotient.
REQ-010 SHALL have port ready_o, output, 1: result_o is valid.
REQ-011 SHALL have port busy_o, output, 1: high in BYZERO and ON.

Function
REQ-012 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-013 In FREE with start_i=1 and annul_i=0, SHALL register the operands and signed_div_i on that edge ("edge 1"); later operand changes SHALL be ignored.
REQ-014 At edge 1, a divisor of 0 SHALL select BYZERO; otherwise ON is selected and the step counter is cleared to 0.
REQ-015 BYZERO SHALL go to END on the next edge, with result_o = 0.
REQ-016 In signed mode, operands SHALL be converted to magnitudes at edge 1; the datapath is unsigned restoring division, one quotient bit per cycle, in a (WIDTH+1)-bit partial remainder.
REQ-017 ON SHALL perform steps on edges 2..WIDTH+1, with the counter reaching WIDTH.
REQ-018 At edge WIDTH+2, SHALL apply sign correction, load result_o, assert ready_o and enter END (edge 34 for WIDTH=32).
REQ-019 Signed-mode sign rules:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend;
- most-negative / -1 yields quotient = most-negative, remainder = 0 (wrap, no flag).
REQ-020 END SHALL hold result_o and ready_o while start_i=1; on start_i=0 it SHALL return to FREE, clearing ready_o and result_o on the same edge.
REQ-021 annul_i=1 in BYZERO or ON SHALL return to FREE on the next edge, with ready_o=0 and result_o=0.
REQ-022 annul_i SHALL be ignored in END.
REQ-023 In FREE, annul_i=1 SHALL take priority over start_i: no acceptance, remain FREE.
REQ-024 start_i deasserted during ON SHALL NOT abort the operation; only annul_i aborts.
REQ-025 ready_o SHALL be high only in END; result_o SHALL be 0 in every state except END.

Reset
REQ-026 rst=0 SHALL immediately, regardless of clk, force the following, including mid-operation:
- state = FREE;
- ready_o = 0, busy_o = 0, result_o = 0;
- counter and partial remainder = 0.
REQ-027 After rst releases, the first acceptance SHALL occur no earlier than the first rising edge with start_i=1.

Configuration
REQ-028 Macro DIV_ITER_EARLY_OUT_EN compiled in: at edge 1, a nonzero divisor with |dividend| < |divisor| (magnitudes per signedness) SHALL go directly FREE->END with quotient 0, remainder = opdata1_i unmodified, and ready_o high after edge 1.
REQ-029 Macro DIV_ITER_EARLY_OUT_EN absent: those operands SHALL take the full ON path with identical results and latency per REQ-018.

Verification
REQ-030 Unsigned 100/7, WIDTH=32 -> after edge 34: ready_o=1, quotient=14, remainder=2; ready_o and result_o stay held until start_i drops.
REQ-031 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-032 Divide by zero, 5/0 -> busy_o=1 after edge 1; after edge 2: ready_o=1, result_o=0.
REQ-033 Abort and restart:
- start 1000/3, annul_i=1 at edge 10 -> FREE at edge 11, ready_o never asserted, result_o=0;
- immediate restart 9/3 -> quotient 3, remainder 0;
- rst=0 pulse mid-ON -> outputs 0 asynchronously.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-035 Unsigned 3/10 -> quotient 0, remainder 3; ready_o after edge 1 with DIV_ITER_EARLY_OUT_EN, after edge 34 without.
